// File: rtl/mem_stage_lsu_pkg.sv
// mem_stage_lsu_pkg: funct3 encodings, LSU FSM states and store lane helpers
package mem_stage_lsu_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    function automatic logic [3:0] be_of(input logic [2:0] f3, input logic [1:0] a);
        return f3[1:0] == 2'b00 ? 4'b0001 << a : f3[1:0] == 2'b01 ? 4'b0011 << a : 4'b1111;
    endfunction
    function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] wd);
        return f3[1:0] == 2'b00 ? {4{wd[7:0]}} : f3[1:0] == 2'b01 ? {2{wd[15:0]}} : wd;
    endfunction
endpackage

// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: single-port data memory req/ready bus
interface mem_stage_lsu_if #(parameter int XLEN = 32);
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [3:0]      dmem_be;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_ready;
    logic [XLEN-1:0] dmem_rdata;
    modport master(output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, input dmem_ready, dmem_rdata);
    modport slave(input dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, output dmem_ready, dmem_rdata);
endinterface

// File: rtl/mem_stage_lsu_load_ext.sv
// load_ext: selects the addressed byte/half of a read word and sign/zero-extends it
module load_ext
    import mem_stage_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  a,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b = rdata[{a, 3'b000} +: 8];
        h = a[1] ? rdata[31:16] : rdata[15:0];
        result = funct3 == F3_B  ? {{24{b[7]}}, b} :
                 funct3 == F3_H  ? {{16{h[15]}}, h} :
                 funct3 == F3_BU ? {24'b0, b} :
                 funct3 == F3_HU ? {16'b0, h} : rdata;
    end
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit with req/ready dmem handshake, stall and fault reporting
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            EX_MEM_MemRead,
    input  logic            EX_MEM_MemWrite,
    input  logic [2:0]      EX_MEM_funct3,
    input  logic [XLEN-1:0] EX_MEM_ALU_result,
    input  logic [XLEN-1:0] EX_MEM_WriteData,
    mem_stage_lsu_if.master dmem,
    output logic [XLEN-1:0] MEM_WB_ReadData,
    output logic            mem_stall,
    output logic            mem_fault
);
    state_t      state, state_n;
    logic        access, illegal, misaligned, launch, reject, done_ok, tout;
    logic [7:0]  cnt;
    logic [2:0]  f3_q;
    logic [1:0]  a_q;
    logic [31:0] ext;

    load_ext u_ext (.rdata(dmem.dmem_rdata), .a(a_q), .funct3(f3_q), .result(ext));

    always_comb begin
        access = EX_MEM_MemRead | EX_MEM_MemWrite;
        illegal = (EX_MEM_MemRead && EX_MEM_MemWrite) ||
                  (EX_MEM_MemRead && (EX_MEM_funct3 == 3'b011 || EX_MEM_funct3[2:1] == 2'b11)) ||
                  (EX_MEM_MemWrite && (EX_MEM_funct3[2] || EX_MEM_funct3[1:0] == 2'b11));
        misaligned = (EX_MEM_funct3[1:0] == 2'b01 && EX_MEM_ALU_result[0]) ||
                     (EX_MEM_funct3[1:0] == 2'b10 && EX_MEM_ALU_result[1:0] != 2'b00);
        launch = state == IDLE && access && !illegal && !misaligned;
        reject = state == IDLE && access && (illegal || misaligned);
        done_ok = state == REQ && dmem.dmem_ready;
        tout = state == REQ && !dmem.dmem_ready && cnt == 8'(TIMEOUT_CYC - 1);
        mem_stall = launch || state == REQ;
        state_n = launch ? REQ : (done_ok || tout) ? DONE : state == DONE ? IDLE : state;
    end

    // Request fields are frozen at launch so dmem sees a stable request for the whole REQ phase
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_be    <= '0;
            dmem.dmem_wdata <= '0;
            MEM_WB_ReadData <= '0;
            mem_fault       <= 1'b0;
            cnt             <= '0;
            f3_q            <= '0;
            a_q             <= '0;
        end else begin
            state     <= state_n;
            mem_fault <= reject || tout;
            if (state == REQ) cnt <= cnt + 8'd1;
            if (launch) begin
                dmem.dmem_req   <= 1'b1;
                dmem.dmem_we    <= EX_MEM_MemWrite;
                dmem.dmem_addr  <= {EX_MEM_ALU_result[XLEN-1:2], 2'b00};
                dmem.dmem_be    <= be_of(EX_MEM_funct3, EX_MEM_ALU_result[1:0]);
                dmem.dmem_wdata <= lane_data(EX_MEM_funct3, EX_MEM_WriteData);
                f3_q            <= EX_MEM_funct3;
                a_q             <= EX_MEM_ALU_result[1:0];
                cnt             <= '0;
            end
            if (done_ok || tout) dmem.dmem_req <= 1'b0;
            if (done_ok && !dmem.dmem_we) MEM_WB_ReadData <= ext;
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: table, corner-sequence and randomized checks of mem_stage_lsu against a behavioural model
module tb_mem_stage_lsu;
    logic        clk, rst;
    logic        EX_MEM_MemRead, EX_MEM_MemWrite;
    logic [2:0]  EX_MEM_funct3;
    logic [31:0] EX_MEM_ALU_result, EX_MEM_WriteData, MEM_WB_ReadData;
    logic        mem_stall, mem_fault;
    int          checks = 0, failures = 0;
    logic [31:0] model_rd = 0;

    mem_stage_lsu_if dmem ();

    mem_stage_lsu dut (
        .clk(clk), .rst(rst),
        .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite),
        .EX_MEM_funct3(EX_MEM_funct3), .EX_MEM_ALU_result(EX_MEM_ALU_result),
        .EX_MEM_WriteData(EX_MEM_WriteData), .dmem(dmem),
        .MEM_WB_ReadData(MEM_WB_ReadData), .mem_stall(mem_stall), .mem_fault(mem_fault)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic r, w; logic [2:0] f3; logic [31:0] a, wd, rw; int wait_n;
        int e_fault; bit e_req; logic [3:0] e_be; logic [31:0] e_wdata, e_rdata; int e_stall;
    } vec_t;

    typedef struct {
        int faults, stalls, reqs, unstable;
        logic [31:0] addr, wdata, rd_fin, rdata; logic [3:0] be; logic we;
    } obs_t;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
        end
    endtask

    function automatic int nb(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic bit m_legal(input logic r, input logic w, input logic [2:0] f3);
        if (r && w) return 0;
        if (r) return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        return f3 inside {3'd0, 3'd1, 3'd2};
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int v = ((1 << nb(f3)) - 1) << (a % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] o;
        for (int i = 0; i < 4; i++) o[8*i +: 8] = wd[8*(i % nb(f3)) +: 8];
        return o;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rw);
        int n = nb(f3);
        longint mask = (longint'(1) << (8 * n)) - 1;
        longint v = (longint'(rw) >> (8 * (a % 4))) & mask;
        if ((f3 == 3'd0 || f3 == 3'd1) && v[8*n-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    // Starts and ends at posedge+1; acts as the memory, answering on REQ cycle wait_n+1 (never if wait_n<0)
    task automatic run_op(input logic r, input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rw, input int wait_n, output obs_t o);
        bit fin = 0;
        o = '{default: 0};
        EX_MEM_MemRead = r; EX_MEM_MemWrite = w; EX_MEM_funct3 = f3;
        EX_MEM_ALU_result = a; EX_MEM_WriteData = wd;
        for (int c = 0; c < 400 && !fin; c++) begin
            #1;
            if (mem_fault) o.faults++;
            if (mem_stall) o.stalls++;
            if (dmem.dmem_req) begin
                if (o.reqs == 0) begin
                    o.addr = dmem.dmem_addr; o.be = dmem.dmem_be; o.we = dmem.dmem_we; o.wdata = dmem.dmem_wdata;
                end else if (o.addr !== dmem.dmem_addr || o.be !== dmem.dmem_be ||
                             o.we !== dmem.dmem_we || o.wdata !== dmem.dmem_wdata) o.unstable++;
                o.reqs++;
                if (o.reqs == wait_n + 1) begin
                    dmem.dmem_ready = 1; dmem.dmem_rdata = rw;
                end
            end
            if (!mem_stall) begin
                fin = 1; o.rd_fin = MEM_WB_ReadData;
            end
            @(posedge clk); #1;
            dmem.dmem_ready = 0; dmem.dmem_rdata = $urandom;
        end
        chk("op_bound", 32'(fin), 32'd1);
        EX_MEM_MemRead = 0; EX_MEM_MemWrite = 0;
        for (int t = 0; t < 2; t++) begin
            #1;
            if (mem_fault) o.faults++;
            if (t == 0) o.rdata = MEM_WB_ReadData;
            @(posedge clk); #1;
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        obs_t o;
        run_op(v.r, v.w, v.f3, v.a, v.wd, v.rw, v.wait_n, o);
        chk({tag, ".fault"}, o.faults, v.e_fault);
        chk({tag, ".stall"}, o.stalls, v.e_stall);
        chk({tag, ".rdata"}, o.rdata, v.e_rdata);
        chk({tag, ".reqs"}, o.reqs, v.e_req ? v.wait_n + 1 : 0);
        if (v.e_req) begin
            chk({tag, ".addr"}, o.addr, {v.a[31:2], 2'b00});
            chk({tag, ".be"}, 32'(o.be), 32'(v.e_be));
            chk({tag, ".we"}, 32'(o.we), 32'(v.w));
            chk({tag, ".stable"}, o.unstable, 0);
            if (v.w) chk({tag, ".wdata"}, o.wdata, v.e_wdata);
            else chk({tag, ".latency"}, o.rd_fin, v.e_rdata);
        end
    endtask

    function automatic vec_t model_vec(input logic r, input logic w, input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] wd, input logic [31:0] rw, input int wait_n);
        vec_t v;
        bit acc = r | w;
        bit ok = acc && m_legal(r, w, f3) && (a % nb(f3)) == 0;
        if (ok && r) model_rd = m_load(f3, a, rw);
        v = '{r, w, f3, a, wd, rw, wait_n, (acc && !ok) ? 1 : 0, ok, m_be(f3, a), m_wdata(f3, wd),
              model_rd, ok ? wait_n + 2 : 0};
        return v;
    endfunction

    vec_t tbl[13];
    obs_t ob;

    initial begin
        tbl[0]  = '{1, 0, 3'b000, 32'h1003, 32'h0,        32'h80FFFF12, 0, 0, 1, 4'b1000, 32'h0,        32'hFFFFFF80, 2};
        tbl[1]  = '{1, 0, 3'b101, 32'h2002, 32'h0,        32'hBEEF0000, 3, 0, 1, 4'b1100, 32'h0,        32'h0000BEEF, 5};
        tbl[2]  = '{0, 1, 3'b000, 32'h0010, 32'h123456AB, 32'h0,        0, 0, 1, 4'b0001, 32'hABABABAB, 32'h0000BEEF, 2};
        tbl[3]  = '{0, 1, 3'b001, 32'h0011, 32'h55AA55AA, 32'h0,        0, 1, 0, 4'b0000, 32'h0,        32'h0000BEEF, 0};
        tbl[4]  = '{1, 1, 3'b000, 32'h0020, 32'h0,        32'h0,        0, 1, 0, 4'b0000, 32'h0,        32'h0000BEEF, 0};
        tbl[5]  = '{1, 0, 3'b010, 32'h0004, 32'h0,        32'hDEADBEEF, 1, 0, 1, 4'b1111, 32'h0,        32'hDEADBEEF, 3};
        tbl[6]  = '{1, 0, 3'b001, 32'h0006, 32'h0,        32'h80017FFF, 0, 0, 1, 4'b1100, 32'h0,        32'hFFFF8001, 2};
        tbl[7]  = '{1, 0, 3'b010, 32'h0002, 32'h0,        32'h11111111, 0, 1, 0, 4'b0000, 32'h0,        32'hFFFF8001, 0};
        tbl[8]  = '{1, 0, 3'b011, 32'h0000, 32'h0,        32'h22222222, 0, 1, 0, 4'b0000, 32'h0,        32'hFFFF8001, 0};
        tbl[9]  = '{0, 1, 3'b100, 32'h0000, 32'h33333333, 32'h0,        0, 1, 0, 4'b0000, 32'h0,        32'hFFFF8001, 0};
        tbl[10] = '{0, 1, 3'b001, 32'h0022, 32'h1234CAFE, 32'h0,        1, 0, 1, 4'b1100, 32'hCAFECAFE, 32'hFFFF8001, 3};
        tbl[11] = '{1, 0, 3'b100, 32'h0001, 32'h0,        32'h00008000, 0, 0, 1, 4'b0010, 32'h0,        32'h00000080, 2};
        tbl[12] = '{1, 0, 3'b000, 32'h0002, 32'h0,        32'h007F0000, 2, 0, 1, 4'b0100, 32'h0,        32'h0000007F, 4};

        rst = 1; EX_MEM_MemRead = 0; EX_MEM_MemWrite = 0; EX_MEM_funct3 = 0;
        EX_MEM_ALU_result = 0; EX_MEM_WriteData = 0; dmem.dmem_ready = 0; dmem.dmem_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.req", 32'(dmem.dmem_req), 0);
        chk("rst.we", 32'(dmem.dmem_we), 0);
        chk("rst.addr", dmem.dmem_addr, 0);
        chk("rst.be", 32'(dmem.dmem_be), 0);
        chk("rst.wdata", dmem.dmem_wdata, 0);
        chk("rst.readdata", MEM_WB_ReadData, 0);
        chk("rst.fault", 32'(mem_fault), 0);
        chk("rst.stall", 32'(mem_stall), 0);
        rst = 0;

        for (int i = 0; i < 13; i++) apply(tbl[i], $sformatf("vec%0d", i));
        model_rd = tbl[12].e_rdata;

        run_op(1, 0, 3'b010, 32'h40, 32'h0, 32'h0, -1, ob);
        chk("tout.fault", ob.faults, 1);
        chk("tout.reqs", ob.reqs, 255);
        chk("tout.stall", ob.stalls, 256);
        chk("tout.rdata", ob.rdata, model_rd);

        for (int i = 0; i < 200; i++) begin
            logic [1:0] k = 2'($urandom_range(0, 3));
            logic r = k == 2'd0 || k == 2'd2;
            logic w = k == 2'd1 || k == 2'd2;
            apply(model_vec(r, w, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                            int'($urandom_range(0, 3))), $sformatf("rnd%0d", i));
        end

        EX_MEM_MemRead = 1; EX_MEM_funct3 = 3'b010; EX_MEM_ALU_result = 32'h80;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rstreq.req_before", 32'(dmem.dmem_req), 1);
        rst = 1; EX_MEM_MemRead = 0;
        @(posedge clk); #1;
        chk("rstreq.req", 32'(dmem.dmem_req), 0);
        chk("rstreq.readdata", MEM_WB_ReadData, 0);
        chk("rstreq.stall", 32'(mem_stall), 0);
        rst = 0; model_rd = 0;
        apply(model_vec(1, 0, 3'b010, 32'h8, 32'h0, 32'h13579BDF, 0), "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
